// File: rtl/mem_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dump_pkg
//  Purpose  : Shared definitions for the memory dump reader: the FSM state
//             encoding, the checksum rotate helper and the read-latency limit.
//  Ports    : none (package)
//  Config   : MEM_DUMP_CHECKSUM_EN (consumer of rotl1 in mem_dump_reader)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_dump_pkg;

    // Deepest read pipeline the latency counter is sized for.
    localparam int MAX_READ_LATENCY = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } dump_state_t;

    // Rotate left by one within the low 'width' bits of a 64-bit carrier.
    // Bits above 'width' in 'value' must be zero; they are zero in the result.
    function automatic logic [63:0] rotl1(input logic [63:0] value, input int width);
        logic [63:0] mask;
        mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return ((value << 1) | (value >> (width - 1))) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dump_reader
//  Purpose  : Walks a contiguous word range through a synchronous read port
//             and streams each word out over valid/ready with its address
//             and a last flag.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             start, base_addr,
//             word_count            - dump request (sampled only when idle)
//             mem_rd_en, mem_addr,
//             mem_rd_data           - read port (READ_LATENCY cycles)
//             out_valid, out_ready,
//             out_data, out_addr,
//             out_last              - output beat stream
//             busy, done            - status; done is a one-cycle pulse
//             checksum              - rotl1/xor signature of sent words
//  Config   : MEM_DUMP_CHECKSUM_EN adds the checksum port and its logic.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
`ifdef MEM_DUMP_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  done
);

    localparam logic [1:0]          c_LAT_LOAD = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] c_CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = 1;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_read_latency
            $error("mem_dump_reader: READ_LATENCY must be 1..MAX_READ_LATENCY");
        end
        if (DATA_WIDTH > 64) begin : g_bad_data_width
            $error("mem_dump_reader: DATA_WIDTH must not exceed 64");
        end
    endgenerate

    dump_state_t             r_state_q,     w_state_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q,      w_addr_d;
    logic [ADDR_WIDTH:0]     r_remaining_q, w_remaining_d;
    logic [1:0]              r_lat_q,       w_lat_d;
    logic [DATA_WIDTH-1:0]   r_data_q,      w_data_d;

    logic w_start_accept;
    logic w_handshake;
    logic w_last;

    assign w_start_accept = (r_state_q == IDLE) && start;
    assign w_handshake    = (r_state_q == SEND) && out_ready;
    assign w_last         = (r_remaining_q == c_CNT_ONE);

    always_comb begin
        w_state_d     = r_state_q;
        w_addr_d      = r_addr_q;
        w_remaining_d = r_remaining_q;
        w_lat_d       = r_lat_q;
        w_data_d      = r_data_q;
        case (r_state_q)
            IDLE: begin
                if (w_start_accept) begin
                    w_addr_d      = base_addr;
                    w_remaining_d = word_count;
                    w_state_d     = (word_count == '0) ? DONE : READ;
                end
            end
            READ: begin
                w_lat_d   = c_LAT_LOAD;
                w_state_d = WAIT;
            end
            WAIT: begin
                // The read data is valid during the last WAIT cycle only.
                if (r_lat_q == 2'd0) begin
                    w_data_d  = mem_rd_data;
                    w_state_d = SEND;
                end else begin
                    w_lat_d = r_lat_q - 2'd1;
                end
            end
            SEND: begin
                if (w_handshake) begin
                    w_remaining_d = r_remaining_q - c_CNT_ONE;
                    if (w_last) begin
                        w_state_d = DONE;
                    end else begin
                        // Natural overflow gives the wrap past the top address.
                        w_addr_d  = r_addr_q + c_ADDR_ONE;
                        w_state_d = READ;
                    end
                end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_addr_q      <= '0;
            r_remaining_q <= '0;
            r_lat_q       <= '0;
            r_data_q      <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_addr_q      <= w_addr_d;
            r_remaining_q <= w_remaining_d;
            r_lat_q       <= w_lat_d;
            r_data_q      <= w_data_d;
        end
    end

    assign mem_rd_en = (r_state_q == READ);
    assign mem_addr  = r_addr_q;
    assign out_valid = (r_state_q == SEND);
    assign out_data  = r_data_q;
    assign out_addr  = r_addr_q;
    assign out_last  = (r_state_q == SEND) && w_last;
    assign busy      = (r_state_q == READ) || (r_state_q == WAIT) || (r_state_q == SEND);
    assign done      = (r_state_q == DONE);

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum_q, w_checksum_d;
    logic [63:0]           w_rot_full;

    assign w_rot_full = rotl1(64'(r_checksum_q), DATA_WIDTH);

    always_comb begin
        w_checksum_d = r_checksum_q;
        if (w_start_accept) begin
            w_checksum_d = '0;
        end else if (w_handshake) begin
            w_checksum_d = w_rot_full[DATA_WIDTH-1:0] ^ r_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum_q <= '0;
        end else begin
            r_checksum_q <= w_checksum_d;
        end
    end

    assign checksum = r_checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_dump_reader
//  Purpose  : Scoreboard bench for mem_dump_reader (READ_LATENCY 1 and 3).
//  Config   : MEM_DUMP_CHECKSUM_EN enables checksum checking.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dump_reader;

    localparam int AW      = 8;
    localparam int CW      = AW + 1;
    localparam int DW      = 32;
    localparam int TIMEOUT = 2000;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT with READ_LATENCY = 1
    logic          reset, start, mem_rd_en, out_valid, out_ready, out_last, busy, done;
    logic [AW-1:0] base_addr, mem_addr, out_addr;
    logic [CW-1:0] word_count;
    logic [DW-1:0] mem_rd_data, out_data;
    // DUT with READ_LATENCY = 3
    logic          start3, mem_rd_en3, out_valid3, out_last3, busy3, done3;
    logic [AW-1:0] base3, mem_addr3, out_addr3;
    logic [CW-1:0] count3;
    logic [DW-1:0] mem_rd_data3, out_data3;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DW-1:0] checksum, checksum3;
`endif

    mem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy),
`ifdef MEM_DUMP_CHECKSUM_EN
        .checksum(checksum),
`endif
        .done(done)
    );

    mem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .base_addr(base3), .word_count(count3),
        .mem_rd_en(mem_rd_en3), .mem_addr(mem_addr3), .mem_rd_data(mem_rd_data3),
        .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3), .out_addr(out_addr3),
        .out_last(out_last3), .busy(busy3),
`ifdef MEM_DUMP_CHECKSUM_EN
        .checksum(checksum3),
`endif
        .done(done3)
    );

    // Memory: data is valid exactly LATENCY cycles after the strobe, garbage otherwise.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rd_pipe1;
    logic [DW-1:0] rd_pipe3 [0:2];
    always @(posedge clk) begin
        rd_pipe1    <= mem_rd_en ? mem[mem_addr] : DW'($urandom);
        rd_pipe3[0] <= mem_rd_en3 ? mem[mem_addr3] : DW'($urandom);
        rd_pipe3[1] <= rd_pipe3[0];
        rd_pipe3[2] <= rd_pipe3[1];
    end
    assign mem_rd_data  = rd_pipe1;
    assign mem_rd_data3 = rd_pipe3[2];

    int n_pass = 0, n_total = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    endtask

    // Scoreboard state
    beat_t         exp_q[$];
    logic [AW-1:0] exp_rd_q[$];
    logic [DW-1:0] exp_done_q[$];
    int            hs_cyc_q[$];
    int            n_hs = 0, n_done = 0, done_cyc = 0, done_target = 0, start_cyc = 0;
    bit            rand_ready = 1'b0;

    initial begin : monitor
        beat_t e, prev;
        logic  prev_stall;
`ifdef MEM_DUMP_CHECKSUM_EN
        logic [DW-1:0] eck;
`endif
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_en) begin
                check("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
                if (exp_rd_q.size() != 0) check("rd_addr", 64'(mem_addr), 64'(exp_rd_q.pop_front()));
            end
            if (out_valid) begin
                check("no_rd_while_valid", 64'(mem_rd_en), 64'd0);
                if (prev_stall) check("stall_hold", 64'({out_addr, out_data, out_last}), 64'(prev));
            end
            if (out_valid && out_ready) begin
                n_hs++;
                hs_cyc_q.push_back(cyc);
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(out_data), 64'(e.data));
                    check("beat_addr", 64'(out_addr), 64'(e.addr));
                    check("beat_last", 64'(out_last), 64'(e.last));
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
                check("busy_low_at_done", 64'(busy), 64'd0);
                check("beats_drained_at_done", 64'(exp_q.size()), 64'd0);
                if (exp_done_q.size() != 0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    eck = exp_done_q.pop_front();
                    check("checksum", 64'(checksum), 64'(eck));
`else
                    void'(exp_done_q.pop_front());
`endif
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = '{addr: out_addr, data: out_data, last: out_last};
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: word i of a dump comes from (base+i) mod 2^AW; the
    // signature is a left-rotate-by-one then xor for each word in order.
    task automatic start_dump(input logic [AW-1:0] base, input int count);
        logic [DW-1:0] ck;
        logic [AW-1:0] a;
        beat_t         b;
        ck = '0;
        for (int i = 0; i < count; i++) begin
            a = AW'((int'(base) + i) % (1 << AW));
            b.addr = a;
            b.data = mem[a];
            b.last = (i == count - 1);
            exp_q.push_back(b);
            exp_rd_q.push_back(a);
            ck = ((ck << 1) | (ck >> (DW - 1))) ^ mem[a];
        end
        exp_done_q.push_back(ck);
        done_target = n_done + 1;
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = base; word_count = CW'(count);
        @(posedge clk);
        #1;
        start = 1'b0; base_addr = AW'($urandom); word_count = CW'($urandom);
        start_cyc = cyc;
        @(negedge clk);
        if (count > 0) begin
            check("busy_after_start", 64'(busy), 64'd1);
            check("rd_after_start", 64'(mem_rd_en), 64'd1);
        end else begin
            check("zero_done_next", 64'(done), 64'd1);
            check("zero_quiet", 64'({busy, mem_rd_en, out_valid}), 64'd0);
        end
    endtask

    task automatic wait_done();
        int i = 0;
        while (n_done < done_target && i < TIMEOUT) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", 64'(n_done >= done_target), 64'd1);
    endtask

    task automatic wait_hs(input int target);
        int i = 0;
        while (n_hs < target && i < TIMEOUT) begin
            @(negedge clk);
            i++;
        end
        check("handshake_seen", 64'(n_hs >= target), 64'd1);
    endtask

    task automatic wait_valid();
        int i = 0;
        while (!out_valid && i < TIMEOUT) begin
            @(negedge clk);
            i++;
        end
        check("valid_seen", 64'(out_valid), 64'd1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int hs0, first_rd, first_v, second_v, nv;
        bit seen3;
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
        start3 = 1'b0; base3 = '0; count3 = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h11111111; mem[1] = 32'h22222222;
        mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done}), 64'd0);
        check("reset_outputs_lat3", 64'({mem_rd_en3, mem_addr3, out_valid3, out_data3, out_addr3, out_last3, busy3, done3}), 64'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("reset_checksum", 64'(checksum), 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic dump with ready high: beats every 3 cycles, done one cycle after the last.
        hs_cyc_q.delete();
        start_dump(8'h00, 4);
        wait_done();
        check("basic_beat_count", 64'(hs_cyc_q.size()), 64'd4);
        if (hs_cyc_q.size() == 4) begin
            for (int j = 0; j < 4; j++) check("basic_beat_cycle", 64'(hs_cyc_q[j] - start_cyc), 64'(2 + 3 * j));
            check("basic_done_cycle", 64'(done_cyc - hs_cyc_q[3]), 64'd1);
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        check("basic_checksum_value", 64'(checksum), 64'h22222222);
`endif

        // Backpressure on beat 2 for three cycles.
        hs0 = n_hs;
        start_dump(8'h00, 4);
        wait_hs(hs0 + 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_valid();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_data", 64'(out_data), 64'h22222222);
            check("stall_addr", 64'(out_addr), 64'd1);
            check("stall_no_rd", 64'(mem_rd_en), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done();

        // Zero length.
        start_dump(8'h55, 0);
        wait_done();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("zero_idle_after", 64'({busy, mem_rd_en, out_valid}), 64'd0);
        end

        // Wrap past the top address.
        start_dump(8'hFE, 3);
        wait_done();

        // Start while busy is ignored, then reset mid-dump.
        hs0 = n_hs;
        start_dump(8'h10, 5);
        wait_valid();
        start = 1'b1; base_addr = 8'h80; word_count = CW'(2);
        @(posedge clk);
        #1 start = 1'b0;
        wait_hs(hs0 + 2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete(); exp_rd_q.delete(); exp_done_q.delete();
        @(negedge clk);
        check("post_reset_outputs", 64'({mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done}), 64'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("post_reset_checksum", 64'(checksum), 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        start_dump(8'h40, 3);
        wait_done();

        // Random dumps under random backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            start_dump(AW'($urandom), $urandom_range(0, 12));
            wait_done();
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Latency 3: valid 4 cycles after the strobe, beats 5 cycles apart.
        @(posedge clk);
        #1 start3 = 1'b1; base3 = 8'h20; count3 = CW'(2);
        @(posedge clk);
        #1 start3 = 1'b0;
        first_rd = -1; first_v = -1; second_v = -1; nv = 0; seen3 = 1'b0;
        for (int i = 0; i < 40 && !seen3; i++) begin
            @(negedge clk);
            if (mem_rd_en3 && first_rd < 0) first_rd = cyc;
            if (out_valid3) begin
                if (nv == 0) first_v = cyc;
                else second_v = cyc;
                check("lat3_data", 64'(out_data3), 64'(mem[8'h20 + nv]));
                check("lat3_addr", 64'(out_addr3), 64'(8'h20 + nv));
                check("lat3_last", 64'(out_last3), 64'(nv == 1));
                nv++;
            end
            if (done3) seen3 = 1'b1;
        end
        check("lat3_done_seen", 64'(seen3), 64'd1);
        check("lat3_beats", 64'(nv), 64'd2);
        check("lat3_rd_to_valid", 64'(first_v - first_rd), 64'd4);
        check("lat3_beat_spacing", 64'(second_v - first_v), 64'd5);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
